vga_timing_gen: RTL

//  Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync counter.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/sync_delay_line.sv | 38 +++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing and per-axis timing helpers.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_CNT_W    = 10;

    // Timing of one raster axis (horizontal in pixels, vertical in lines)
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    function automatic int unsigned axis_total(axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // First count inside the sync pulse
    function automatic int unsigned axis_sync_beg(axis_timing_t t);
        return t.active + t.fp;
    endfunction

    // First count after the sync pulse
    function automatic int unsigned axis_sync_end(axis_timing_t t);
        return t.active + t.fp + t.sync;
    endfunction

    // All intervals non-zero and the last count fits in cnt_w bits
    function automatic bit axis_ok(axis_timing_t t, int unsigned cnt_w);
        bit nonzero;
        nonzero = (t.active != 0) && (t.fp != 0) && (t.sync != 0) && (t.bp != 0);
        return nonzero && (((axis_total(t) - 1) >> cnt_w) == 0);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register with a programmable reset value; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int unsigned         WIDTH   = 1,
    parameter int unsigned         DEPTH   = 1,
    parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, reset, en};
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stages [DEPTH];

        // Shift one stage per enable tick; reset loads the idle pattern everywhere
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stages[i] <= RST_VAL;
                end
            end else if (en) begin
                stages[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pipeline-matched sync/valid copies.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter logic        HSYNC_POL  = 1'b0,
    parameter logic        VSYNC_POL  = 1'b0,
    parameter int unsigned PIPE_DELAY = 0,
    parameter int unsigned CNT_W      = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] col_count,
    output logic [CNT_W-1:0] row_count,
    output logic             valid,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync_d,
    output logic             vsync_d,
    output logic             valid_d
);

    localparam axis_timing_t H_CFG = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam axis_timing_t V_CFG = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(axis_total(H_CFG) - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(axis_total(V_CFG) - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(axis_sync_beg(H_CFG));
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(axis_sync_end(H_CFG));
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(axis_sync_beg(V_CFG));
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(axis_sync_end(V_CFG));

    // {hsync, vsync, valid} in their inactive state
    localparam logic [2:0] SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    if (!axis_ok(H_CFG, CNT_W) || !axis_ok(V_CFG, CNT_W)) begin : g_cfg_check
        $error("vga_timing_gen: zero timing interval or CNT_W too small for the raster");
    end

    logic [CNT_W-1:0] col_nxt;
    logic [CNT_W-1:0] row_nxt;
    logic             valid_nxt;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             line_nxt;
    logic             frame_nxt;

    // Next raster position and its decode, so flags register alongside the counters
    always_comb begin
        col_nxt = col_count + CNT_W'(1);
        row_nxt = row_count;
        if (col_count == H_LAST) begin
            col_nxt = '0;
            row_nxt = (row_count == V_LAST) ? '0 : row_count + CNT_W'(1);
        end
        valid_nxt = (col_nxt < H_ACT) && (row_nxt < V_ACT);
        hsync_nxt = ((col_nxt >= HS_BEG) && (col_nxt < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_nxt = ((row_nxt >= VS_BEG) && (row_nxt < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        line_nxt  = (col_nxt == '0);
        frame_nxt = (col_nxt == '0) && (row_nxt == '0);
    end

    // Counter and decoded flags; reset parks on the last position so the first tick lands on 0,0
    always_ff @(posedge clk) begin
        if (reset) begin
            col_count   <= H_LAST;
            row_count   <= V_LAST;
            valid       <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            col_count   <= col_nxt;
            row_count   <= row_nxt;
            valid       <= valid_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            line_start  <= line_nxt;
            frame_start <= frame_nxt;
        end
    end

    logic [2:0] sync_vec;
    logic [2:0] sync_vec_d;

    assign sync_vec = {hsync, vsync, valid};

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .d     (sync_vec),
        .q     (sync_vec_d)
    );

    assign {hsync_d, vsync_d, valid_d} = sync_vec_d;

endmodule
